// File: rtl/multi_dataflow_kernel_adapter_ctrl.sv
// Handshake/control core for an N-in/M-out kernel adapter: per-channel quotas gate inputs and raise ready/done/idle.
// Latency: handshake visible in counters next cycle; ready_o/done_o one cycle after the completing handshake.
module multi_dataflow_kernel_adapter_ctrl #(
  parameter int unsigned N_IN  = 1,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   start_i,
  input  logic [N_IN*CNT_W-1:0]  in_quota_i,
  input  logic [N_OUT*CNT_W-1:0] out_quota_i,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN-1:0]        in_ready_i,
  input  logic [N_OUT-1:0]       out_valid_i,
  input  logic [N_OUT-1:0]       out_ready_i,
  output logic [N_IN-1:0]        in_gate_o,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   idle_o,
  output logic                   overflow_o,
  output logic [N_IN*CNT_W-1:0]  in_cnt_o,
  output logic [N_OUT*CNT_W-1:0] out_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;
  logic [N_IN-1:0][CNT_W-1:0]  in_cnt_q, in_cnt_d, in_quota_q, in_quota_d;
  logic [N_OUT-1:0][CNT_W-1:0] out_cnt_q, out_cnt_d, out_quota_q, out_quota_d;
  logic overflow_q, overflow_d, ready_q, ready_d;
  logic in_done_cur, in_done_nxt, out_done_nxt;
  logic [N_IN-1:0] gate;
  logic unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // Gate depends on registers only, so the wrapper can AND it into valid and ready without loops.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      gate[i] = (state_q == RUN) && (in_cnt_q[i] < in_quota_q[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    in_quota_d   = in_quota_q;
    out_quota_d  = out_quota_q;
    overflow_d   = overflow_q;
    ready_d      = 1'b0;
    in_done_cur  = 1'b1;
    in_done_nxt  = 1'b1;
    out_done_nxt = 1'b1;

    if (start_i) begin
      // Start always wins: any handshake or completion in this cycle is discarded.
      state_d     = RUN;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      in_quota_d  = in_quota_i;
      out_quota_d = out_quota_i;
      overflow_d  = 1'b0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid_i[i] && in_ready_i[i] && gate[i]) begin
          in_cnt_d[i] = in_cnt_q[i] + CNT_W'(1);
        end
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (out_valid_i[j] && out_ready_i[j]) begin
          if (out_cnt_q[j] == out_quota_q[j]) begin
            overflow_d = 1'b1;
          end else begin
            out_cnt_d[j] = out_cnt_q[j] + CNT_W'(1);
          end
        end
      end
      for (int i = 0; i < N_IN; i++) begin
        in_done_cur = in_done_cur & (in_cnt_q[i] == in_quota_q[i]);
        in_done_nxt = in_done_nxt & (in_cnt_d[i] == in_quota_q[i]);
      end
      for (int j = 0; j < N_OUT; j++) begin
        out_done_nxt = out_done_nxt & (out_cnt_d[j] == out_quota_q[j]);
      end
      // Edge-detected so jobs with all-zero input quotas never pulse ready.
      ready_d = in_done_nxt & ~in_done_cur;
      if (out_done_nxt) begin
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      in_quota_q  <= '0;
      out_quota_q <= '0;
      overflow_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      in_quota_q  <= in_quota_d;
      out_quota_q <= out_quota_d;
      overflow_q  <= overflow_d;
      ready_q     <= ready_d;
    end
  end

  assign in_gate_o  = gate;
  assign ready_o    = ready_q;
  assign done_o     = (state_q == DONE);
  assign idle_o     = (state_q == IDLE);
  assign overflow_o = overflow_q;
  assign in_cnt_o   = in_cnt_q;
  assign out_cnt_o  = out_cnt_q;

endmodule

// File: tb/tb_multi_dataflow_kernel_adapter_ctrl.sv
// Directed bench for multi_dataflow_kernel_adapter_ctrl with N_IN=2, N_OUT=2, CNT_W=16.
module tb_multi_dataflow_kernel_adapter_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        test_mode_i;
  logic        start_i;
  logic [31:0] in_quota_i, out_quota_i;
  logic [1:0]  in_valid_i, in_ready_i, out_valid_i, out_ready_i;
  logic [1:0]  in_gate_o;
  logic        ready_o, done_o, idle_o, overflow_o;
  logic [31:0] in_cnt_o, out_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  multi_dataflow_kernel_adapter_ctrl #(.N_IN(2), .N_OUT(2), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .start_i(start_i),
    .in_quota_i(in_quota_i), .out_quota_i(out_quota_i),
    .in_valid_i(in_valid_i), .in_ready_i(in_ready_i),
    .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
    .in_gate_o(in_gate_o), .ready_o(ready_o), .done_o(done_o), .idle_o(idle_o),
    .overflow_o(overflow_o), .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
  );

  typedef struct {
    logic        start;
    logic [1:0]  iv, ir, ov, orr;
    logic [15:0] iq0, iq1, oq0, oq1;
    logic [1:0]  e_gate;
    logic        e_rdy, e_dn, e_idl, e_ovf;
    logic [15:0] e_c0, e_c1, e_o0;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(logic st, logic [1:0] iv, logic [1:0] ir, logic [1:0] ov, logic [1:0] orr,
                              logic [15:0] iq0, logic [15:0] iq1, logic [15:0] oq0, logic [15:0] oq1,
                              logic [1:0] g, logic r, logic d, logic i, logic o,
                              logic [15:0] c0, logic [15:0] c1, logic [15:0] o0);
    vec_t v;
    v.start = st; v.iv = iv; v.ir = ir; v.ov = ov; v.orr = orr;
    v.iq0 = iq0; v.iq1 = iq1; v.oq0 = oq0; v.oq1 = oq1;
    v.e_gate = g; v.e_rdy = r; v.e_dn = d; v.e_idl = i; v.e_ovf = o;
    v.e_c0 = c0; v.e_c1 = c1; v.e_o0 = o0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] g, input logic r, input logic d,
                         input logic i, input logic o, input logic [15:0] c0, input logic [15:0] c1,
                         input logic [15:0] o0);
    chk({tag, ".gate"}, 32'(in_gate_o), 32'(g));
    chk({tag, ".ready"}, 32'(ready_o), 32'(r));
    chk({tag, ".done"}, 32'(done_o), 32'(d));
    chk({tag, ".idle"}, 32'(idle_o), 32'(i));
    chk({tag, ".ovf"}, 32'(overflow_o), 32'(o));
    chk({tag, ".in0"}, 32'(in_cnt_o[15:0]), 32'(c0));
    chk({tag, ".in1"}, 32'(in_cnt_o[31:16]), 32'(c1));
    chk({tag, ".out0"}, 32'(out_cnt_o[15:0]), 32'(o0));
  endtask

  task automatic drive(input logic st, input logic [1:0] iv, input logic [1:0] ir,
                       input logic [1:0] ov, input logic [1:0] orr);
    start_i = st; in_valid_i = iv; in_ready_i = ir; out_valid_i = ov; out_ready_i = orr;
  endtask

  task automatic quotas(input logic [15:0] iq0, input logic [15:0] iq1,
                        input logic [15:0] oq0, input logic [15:0] oq1);
    in_quota_i = {iq1, iq0}; out_quota_i = {oq1, oq0};
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Basic job: in quotas {3,2}, out quota 1 (channel 1 quota 0); later quota changes must be ignored.
    tbl[0] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 3, 2, 1, 0,  2'b11, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 2'b11, 2'b01, 2'b00, 2'b00, 9, 9, 9, 9,  2'b11, 0, 0, 0, 0, 1, 0, 0);
    tbl[2] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 9, 9, 9, 9,  2'b11, 0, 0, 0, 0, 2, 1, 0);
    tbl[3] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 9, 9, 9, 9,  2'b00, 1, 0, 0, 0, 3, 2, 0);
    tbl[4] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 9, 9, 9, 9,  2'b00, 0, 0, 0, 0, 3, 2, 0);
    tbl[5] = mk(0, 2'b00, 2'b00, 2'b01, 2'b01, 9, 9, 9, 9,  2'b00, 0, 1, 0, 0, 3, 2, 1);
    tbl[6] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 9, 9, 9, 9,  2'b00, 0, 0, 1, 0, 3, 2, 1);
    tbl[7] = mk(0, 2'b11, 2'b11, 2'b01, 2'b01, 9, 9, 9, 9,  2'b00, 0, 0, 1, 0, 3, 2, 1);

    rst_ni = 1'b0; test_mode_i = 1'b0;
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00);
    quotas(0, 0, 0, 0);
    #12;
    chk_all("reset", 2'b00, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();

    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].start, tbl[k].iv, tbl[k].ir, tbl[k].ov, tbl[k].orr);
      quotas(tbl[k].iq0, tbl[k].iq1, tbl[k].oq0, tbl[k].oq1);
      cyc();
      chk_all($sformatf("vec%0d", k), tbl[k].e_gate, tbl[k].e_rdy, tbl[k].e_dn, tbl[k].e_idl,
              tbl[k].e_ovf, tbl[k].e_c0, tbl[k].e_c1, tbl[k].e_o0);
    end

    // Closed gate: valid/ready held high after quota 4 is consumed.
    quotas(4, 1, 1, 0);
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    drive(0, 2'b01, 2'b01, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) cyc();
    chk_all("gate_full", 2'b10, 0, 0, 0, 0, 4, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("gate_hold.in0", 32'(in_cnt_o[15:0]), 32'd4);
      chk("gate_hold.gate0", 32'(in_gate_o[0]), 32'd0);
    end

    // Overflow: out quota {2,1}; three handshakes on channel 0 keep the job in RUN.
    quotas(0, 0, 2, 1);
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    chk_all("ovf_start", 2'b00, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b00, 2'b00, 2'b01, 2'b01);
    cyc();
    cyc();
    chk_all("ovf_two", 2'b00, 0, 0, 0, 0, 0, 0, 2);
    cyc();
    chk_all("ovf_three", 2'b00, 0, 0, 0, 1, 0, 0, 2);
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // Restart clears overflow; then 5 input handshakes per channel before an abort.
    quotas(8, 8, 1, 0);
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    chk_all("restart1", 2'b11, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++) cyc();
    chk_all("mid5", 2'b11, 0, 0, 0, 0, 5, 5, 0);
    quotas(2, 1, 0, 1);
    drive(1, 2'b11, 2'b11, 2'b00, 2'b00);
    cyc();
    chk_all("abort", 2'b11, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00);
    cyc();
    chk_all("new_q1", 2'b01, 0, 0, 0, 0, 1, 1, 0);
    cyc();
    chk_all("new_q2", 2'b00, 1, 0, 0, 0, 2, 1, 0);

    // Start coincides with the final output handshake: start wins, next job has all-zero quotas.
    quotas(0, 0, 0, 0);
    drive(1, 2'b00, 2'b00, 2'b10, 2'b10);
    cyc();
    chk_all("start_wins", 2'b00, 0, 0, 0, 0, 0, 0, 0);
    chk("start_wins.out1", 32'(out_cnt_o[31:16]), 32'd0);
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    chk_all("zero_done", 2'b00, 0, 1, 0, 0, 0, 0, 0);
    cyc();
    chk_all("zero_idle", 2'b00, 0, 0, 1, 0, 0, 0, 0);

    // Async reset mid-RUN with counters 7/3 and overflow set.
    quotas(10, 10, 1, 1);
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc();
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) cyc();
    drive(0, 2'b01, 2'b01, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) cyc();
    drive(0, 2'b00, 2'b00, 2'b01, 2'b01);
    cyc();
    cyc();
    chk_all("pre_rst", 2'b11, 0, 0, 0, 1, 7, 3, 1);
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all("mid_rst", 2'b00, 0, 0, 1, 0, 0, 0, 0);
    rst_ni = 1'b1;
    cyc();
    chk("post_rst.idle", 32'(idle_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_dataflow_kernel_adapter_ctrl.md
Name: multi_dataflow_kernel_adapter_ctrl

Overview:
- Parametrised handshake/control core for the next-generation HWPE kernel adapter, supporting N input and M output streams.
- Replaces the fixed "one input = ready" and "one output = done" rule with per-channel programmable quotas.
- Gates input streams once their quota is consumed and produces ready/done/idle flags for the hwpe-engine FSM.
- Sits beside the reconfigurable datapath. It observes stream handshakes and drives input-side gating.

Parameters:
- N_IN, 1, number of input streams monitored and gated.
- N_OUT, 1, number of output streams monitored.
- CNT_W, 16, width of each per-channel quota and counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- test_mode_i  in  1  reserved; ignored.
- start_i  in  1  one-cycle start of a job; also restarts/aborts a running job.
- in_quota_i  in  N_IN*CNT_W  handshakes expected per input channel per job; channel i at bits [i*CNT_W +: CNT_W].
- out_quota_i  in  N_OUT*CNT_W  handshakes expected per output channel per job.
- in_valid_i  in  N_IN  input stream valid (observed).
- in_ready_i  in  N_IN  input stream ready from kernel (observed).
- out_valid_i  in  N_OUT  output stream valid (observed).
- out_ready_i  in  N_OUT  output stream ready (observed).
- in_gate_o  out  N_IN  1 = channel may handshake; the wrapper ANDs it into valid and ready.
- ready_o  out  1  one-cycle pulse: all input quotas consumed.
- done_o  out  1  one-cycle pulse: all output quotas produced.
- idle_o  out  1  block not operating.
- overflow_o  out  1  sticky: output handshake beyond its quota.
- in_cnt_o  out  N_IN*CNT_W  current input counters.
- out_cnt_o  out  N_OUT*CNT_W  current output counters.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, all counters 0.
  - idle_o=1; ready_o, done_o, overflow_o = 0; in_gate_o = 0.
  - Reset mid-job aborts immediately with these values.
- Quotas are sampled into internal registers on start_i. Changes to the quota inputs during a job have no effect.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start_i -> RUN; counters cleared, quotas latched, overflow_o cleared.
  - RUN: counts handshakes.
    - Input channel i counts when in_valid_i[i] & in_ready_i[i] & in_gate_o[i].
    - Output channel j counts when out_valid_i[j] & out_ready_i[j].
    - When every output channel has cnt==quota (next-state values included) -> DONE.
  - DONE: done_o=1 for exactly this one cycle.
    - start_i -> RUN (restart; idle_o stays 0).
    - Otherwise -> IDLE.
- in_gate_o[i] = (state==RUN) & (in_cnt[i] < in_quota[i]). It is a combinational function of registers only and never depends on valid/ready.
- Input-complete condition: all in_cnt==in_quota. ready_o is a registered one-cycle pulse on its 0->1 transition while in RUN.
- Latencies:
  - start_i at cycle t -> idle_o=0 and gates open at t+1.
  - Handshake at t -> visible in counter at t+1.
  - Last input handshake at t -> ready_o at t+1.
  - Last output handshake at t -> done_o at t+1 -> idle_o=1 at t+2 if no start.
- Zero quota: the channel is complete from the start and its gate is never opened.
  - All output quotas 0 -> RUN for 1 cycle, then DONE.
- Output handshake in RUN with out_cnt[j]==out_quota[j]:
  - Counter holds (saturates).
  - overflow_o set; it stays set until the next start_i or reset.
- Output handshakes outside RUN are ignored and not flagged.
- start_i while in RUN: abort; counters cleared, quotas relatched, remain in RUN; no done_o. Handshakes in the same cycle as start_i are discarded (start wins).
- start_i in the same cycle as final completion: start wins; no done_o.
- Counters are CNT_W bits. A quota of 2^CNT_W-1 is legal and no wrap is possible (gate/saturation).

Test Plan:
- N_IN=2, N_OUT=1, in_quota={3,2}, out_quota=1; stream 3 and 2 inputs, then 1 output -> ready_o pulses 1 cycle after the 5th input handshake; in_gate_o[0] low after 3 handshakes; done_o 1 cycle after the output; idle_o=1 one cycle later.
- in_valid held high on a closed gate (cnt==quota=4) for 10 cycles -> in_cnt stays 4, no extra counts.
- out_quota=2; three output handshakes in RUN -> out_cnt_o=2, overflow_o=1 until the next start_i, then 0.
- start_i reasserted mid-job with in_cnt=5 -> counters 0 next cycle, no done_o, job restarts with newly latched quotas.
- All quotas 0 -> RUN at t+1, done_o at t+2, idle_o at t+3; ready_o never pulses.
- rst_ni pulled low mid-RUN with counters 7/3 -> immediately idle_o=1, gates 0, counters 0, overflow_o 0.
